// File: rtl/lbus_fifo_pkg.sv
// Shared defaults and payload types for the lbus synchronous FIFO slice.
package lbus_fifo_pkg;

   localparam int unsigned LBUS_WIDTH     = 32;
   localparam int unsigned LBUS_ADDR_W    = 10;
   localparam int unsigned LBUS_AEMPTY_TH = 4;
   localparam int unsigned LBUS_AFULL_TH  = (2 ** LBUS_ADDR_W) - 4;

   typedef struct packed {
      logic empty;
      logic aempty;
      logic full;
      logic afull;
   } lbus_fifo_flags_t;

endpackage

// File: rtl/lbus_fifo_sync_core_if.sv
// Write/read handshake and status bundle between the FIFO core and its user.
interface lbus_fifo_sync_core_if
   import lbus_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = LBUS_WIDTH,
   parameter int unsigned ADDR_W = LBUS_ADDR_W
);
   logic              wr_en;
   logic [WIDTH-1:0]  din;
   logic              fifo_rd_en;
   logic [WIDTH-1:0]  fifo_dout;
   logic              fifo_empty;
   logic              fifo_aempty;
   logic              full;
   logic              afull;
   logic [ADDR_W-1:0] fifo_MEMRADDR;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, din, fifo_rd_en,
      input  fifo_dout, fifo_empty, fifo_aempty, full, afull,
             fifo_MEMRADDR, count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, fifo_rd_en,
      output fifo_dout, fifo_empty, fifo_aempty, full, afull,
             fifo_MEMRADDR, count, overflow, underflow
   );
endinterface

// File: rtl/lbus_fifo_sync_ram.sv
// Simple dual-port RAM: synchronous write, registered read (latency 1), no reset.
module lbus_fifo_sync_ram #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];

   // Read register only loads on a read so the output holds between reads.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/lbus_fifo_sync_core.sv
// Single-clock FIFO core: pointers, occupancy, registered flags and sticky errors around a 1-cycle RAM.
module lbus_fifo_sync_core
   import lbus_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = LBUS_WIDTH,
   parameter int unsigned ADDR_W    = LBUS_ADDR_W,
   parameter int unsigned AEMPTY_TH = LBUS_AEMPTY_TH,
   parameter int unsigned AFULL_TH  = (2 ** ADDR_W) - 4
) (
   input logic                  pos_rclk,
   input logic                  reset_rclk,
   lbus_fifo_sync_core_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [CNT_W-1:0]  count_q;
   lbus_fifo_flags_t  flags_q;
   logic              overflow_q;
   logic              underflow_q;
   logic              dout_vld;
   logic [WIDTH-1:0]  ram_q;

   logic              wr_acc_c;
   logic              rd_acc_c;
   logic [CNT_W-1:0]  count_nxt_c;

   // Acceptance uses the registered flags; a full FIFO rejects writes even alongside a read.
   always_comb begin
      wr_acc_c    = bus.wr_en & ~flags_q.full;
      rd_acc_c    = bus.fifo_rd_en & ~flags_q.empty;
      count_nxt_c = count_q;
      if (wr_acc_c && !rd_acc_c) begin
         count_nxt_c = count_q + CNT_W'(1);
      end else if (rd_acc_c && !wr_acc_c) begin
         count_nxt_c = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge pos_rclk or negedge reset_rclk) begin
      if (!reset_rclk) begin
         wptr        <= '0;
         rptr        <= '0;
         count_q     <= '0;
         flags_q     <= '{empty: 1'b1, aempty: 1'b1, full: 1'b0, afull: 1'b0};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_vld    <= 1'b0;
      end else begin
         if (wr_acc_c) wptr <= wptr + ADDR_W'(1);
         if (rd_acc_c) rptr <= rptr + ADDR_W'(1);
         count_q        <= count_nxt_c;
         // Flags come from the next count so they line up with count after the edge.
         flags_q.empty  <= (count_nxt_c == '0);
         flags_q.aempty <= (count_nxt_c <= CNT_W'(AEMPTY_TH));
         flags_q.full   <= (count_nxt_c == CNT_W'(DEPTH));
         flags_q.afull  <= (count_nxt_c >= CNT_W'(AFULL_TH));
         if (bus.wr_en && flags_q.full)       overflow_q  <= 1'b1;
         if (bus.fifo_rd_en && flags_q.empty) underflow_q <= 1'b1;
         if (rd_acc_c)                        dout_vld    <= 1'b1;
      end
   end

   lbus_fifo_sync_ram #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (pos_rclk),
      .we    (wr_acc_c),
      .waddr (wptr),
      .wdata (bus.din),
      .re    (rd_acc_c),
      .raddr (rptr),
      .rdata (ram_q)
   );

   // RAM output register has no reset; mask it until the first read after reset.
   assign bus.fifo_dout     = dout_vld ? ram_q : '0;
   assign bus.fifo_empty    = flags_q.empty;
   assign bus.fifo_aempty   = flags_q.aempty;
   assign bus.full          = flags_q.full;
   assign bus.afull         = flags_q.afull;
   assign bus.fifo_MEMRADDR = rptr;
   assign bus.count         = count_q;
   assign bus.overflow      = overflow_q;
   assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_lbus_fifo_sync_core.sv
// Scoreboard bench for lbus_fifo_sync_core with default parameters (DEPTH 1024).
module tb_lbus_fifo_sync_core;
   localparam int DEPTH = 1024;
   localparam int AE_TH = 4;
   localparam int AF_TH = 1020;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   lbus_fifo_sync_core_if #(.WIDTH(32), .ADDR_W(10)) bus ();

   lbus_fifo_sync_core u_dut (
      .pos_rclk   (clk),
      .reset_rclk (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_err    = 0;
   logic [31:0] sb[$];
   int          m_count  = 0;
   int          m_rptr   = 0;
   logic [31:0] m_dout   = '0;
   logic        m_ovf    = 1'b0;
   logic        m_unf    = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   task automatic check_all();
      check("dout",      64'(bus.fifo_dout),     64'(m_dout));
      check("count",     64'(bus.count),         64'(m_count));
      check("empty",     64'(bus.fifo_empty),    64'(m_count == 0));
      check("aempty",    64'(bus.fifo_aempty),   64'(m_count <= AE_TH));
      check("full",      64'(bus.full),          64'(m_count == DEPTH));
      check("afull",     64'(bus.afull),         64'(m_count >= AF_TH));
      check("raddr",     64'(bus.fifo_MEMRADDR), 64'(m_rptr));
      check("overflow",  64'(bus.overflow),      64'(m_ovf));
      check("underflow", 64'(bus.underflow),     64'(m_unf));
   endtask

   task automatic model_clear();
      m_count = 0;
      m_rptr  = 0;
      m_dout  = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      sb.delete();
   endtask

   // One clock: drive at negedge, predict, then compare just after the rising edge.
   task automatic step(input logic wr, input logic [31:0] d, input logic rd);
      logic wa, ra;
      @(negedge clk);
      wa = wr && (m_count != DEPTH);
      ra = rd && (m_count != 0);
      bus.wr_en      = wr;
      bus.din        = d;
      bus.fifo_rd_en = rd;
      @(posedge clk);
      #1;
      if (wa) sb.push_back(d);
      if (ra) begin
         m_dout = sb.pop_front();
         m_rptr = (m_rptr + 1) % DEPTH;
      end
      if (wr && !wa) m_ovf = 1'b1;
      if (rd && !ra) m_unf = 1'b1;
      if (wa && !ra) m_count++;
      else if (ra && !wa) m_count--;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n          = 1'b0;
      bus.wr_en      = 1'b0;
      bus.fifo_rd_en = 1'b0;
      bus.din        = '0;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.wr_en      = 1'b0;
      bus.din        = '0;
      bus.fifo_rd_en = 1'b0;
      do_reset();

      // Single word: empty falls after the write, data two cycles after it, empty rises again.
      step(1'b1, 32'hA5, 1'b0);
      check("a5_empty_fall", 64'(bus.fifo_empty), 64'd0);
      step(1'b0, '0, 1'b1);
      check("a5_dout", 64'(bus.fifo_dout), 64'hA5);
      check("a5_empty_rise", 64'(bus.fifo_empty), 64'd1);
      // Read while empty: underflow, pointer and data hold.
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      check("unf_flag", 64'(bus.underflow), 64'd1);
      check("unf_raddr", 64'(bus.fifo_MEMRADDR), 64'd1);
      check("unf_dout", 64'(bus.fifo_dout), 64'hA5);

      // Fill to full (afull at 1020), overflow attempt, then drain (aempty at 4).
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0);
      check("fill_full", 64'(bus.full), 64'd1);
      check("fill_count", 64'(bus.count), 64'd1024);
      step(1'b1, 32'hDEAD_BEEF, 1'b0);
      check("ovf_flag", 64'(bus.overflow), 64'd1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
      check("drain_last", 64'(bus.fifo_dout), 64'd1023);

      // Streaming at count 5 with pointer wrap.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 32'(100 + i), 1'b0);
      for (int i = 0; i < 2000; i++) step(1'b1, $urandom, 1'b1);
      check("stream_count", 64'(bus.count), 64'd5);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

      // Reset mid-operation at count 37, then reuse.
      do_reset();
      for (int i = 0; i < 40; i++) step(1'b1, 32'(32'h1000 + i), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      check("pre_rst_count", 64'(bus.count), 64'd37);
      do_reset();
      check("post_rst_raddr", 64'(bus.fifo_MEMRADDR), 64'd0);
      for (int i = 0; i < 8; i++) step(1'b1, 32'(32'h2000 + i), 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
      check("post_rst_dout", 64'(bus.fifo_dout), 64'h2007);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/lbus_fifo_sync_core.md
LBUS_FIFO_SYNC_CORE -- requirements
Module: lbus_fifo_sync_core

Interface
REQ-001 SHALL have parameter WIDTH, 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, 10, log2 of depth; DEPTH = 2^ADDR_W entries.
REQ-003 SHALL have parameter AEMPTY_TH, 4, fifo_aempty asserts when count <= AEMPTY_TH.
REQ-004 SHALL have parameter AFULL_TH, DEPTH-4, afull asserts when count >= AFULL_TH.
REQ-005 SHALL have port pos_rclk  in  1  single clock for the write and read sides.
REQ-006 SHALL have port reset_rclk  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  in  1  active-high write request.
REQ-008 SHALL have port din  in  WIDTH  write data.
REQ-009 SHALL have port fifo_rd_en  in  1  active-high read request from the downstream FWFT stage.
REQ-010 SHALL have port fifo_dout  out  WIDTH  registered read data.
REQ-011 SHALL have port fifo_empty  out  1  count == 0.
REQ-012 SHALL have port fifo_aempty  out  1  count <= AEMPTY_TH.
REQ-013 SHALL have port full  out  1  count == DEPTH.
REQ-014 SHALL have port afull  out  1  count >= AFULL_TH.
REQ-015 SHALL have port fifo_MEMRADDR  out  ADDR_W  read pointer, i.e. the address of the next entry read.
REQ-016 SHALL have port count  out  ADDR_W+1  current occupancy.
REQ-017 SHALL have port overflow  out  1  sticky flag for a write rejected while full.
REQ-018 SHALL have port underflow  out  1  sticky flag for a read rejected while empty.

Function
REQ-019 SHALL accept a write (wr_acc) when wr_en=1 and full=0, storing din at wptr on the same edge.
REQ-020 SHALL reject a write when full=1, even if a read is accepted in the same cycle; SHALL set overflow.
REQ-021 SHALL accept a read (rd_acc) when fifo_rd_en=1 and fifo_empty=0; SHALL reject and set underflow otherwise.
REQ-022 SHALL present the data at rptr on fifo_dout exactly one cycle after rd_acc (latency 1).
REQ-023 SHALL hold fifo_dout stable in all cycles without rd_acc.
REQ-024 SHALL increment wptr and rptr by 1 per accepted operation, wrapping modulo DEPTH (DEPTH-1 -> 0).
REQ-025 SHALL update count as +1 (write only), -1 (read only), unchanged (both or neither).
REQ-026 SHALL derive all flags (fifo_empty, fifo_aempty, full, afull) as registered values consistent with count in the same cycle.
REQ-027 SHALL deassert fifo_empty in the cycle after the first accepted write into an empty FIFO, so that write-to-first-read-data latency is 2 cycles.
REQ-028 SHALL drive fifo_MEMRADDR as rptr after the edge on which it updates.
REQ-029 SHALL keep wptr != rptr whenever count is between 1 and DEPTH-1, so no read/write collision can occur on the same RAM address.
REQ-030 SHALL keep overflow and underflow set until reset.

Reset
REQ-031 SHALL, while reset_rclk=0, clear wptr, rptr, count, fifo_dout, overflow and underflow to 0, set fifo_empty=1 and fifo_aempty=1, and clear full and afull to 0.
REQ-032 SHALL discard stored contents on reset asserted mid-operation; the RAM array itself SHALL NOT be reset.
REQ-033 SHALL ignore wr_en and fifo_rd_en in the first edge after reset deassertion only if they are sampled during reset; normal acceptance SHALL apply from the first edge with reset_rclk=1.

Structure
REQ-034 SHALL place default WIDTH, ADDR_W, AEMPTY_TH and AFULL_TH constants in shared package lbus_fifo_pkg.
REQ-035 SHALL instantiate one sub-module, lbus_fifo_sync_ram: simple dual-port memory, write on pos_rclk, registered read, latency 1, no reset.
REQ-036 SHALL keep pointers, count, flags and error logic in lbus_fifo_sync_core.

Verification
REQ-037 SHALL cover this case: after reset, write 0xA5 once, then hold fifo_rd_en=1 -> fifo_empty falls 1 cycle after the write, fifo_dout=0xA5 2 cycles after the write, and fifo_empty rises again.
REQ-038 SHALL cover this case: write 1024 sequential values with ADDR_W=10 -> full=1 and count=1024; a further write -> overflow=1 and contents unchanged.
REQ-039 SHALL cover this case: fill 1020 entries -> afull rises at count 1020; drain to count 4 -> fifo_aempty rises.
REQ-040 SHALL cover this case: continuous simultaneous writes and reads at count=5 for 2000 cycles -> count stays 5, pointers wrap, and data order is preserved.
REQ-041 SHALL cover this case: fifo_rd_en=1 while empty -> underflow=1, and rptr and fifo_dout unchanged.
REQ-042 SHALL cover this case: assert reset at count=37 -> the next cycle shows count=0, fifo_empty=1 and fifo_MEMRADDR=0; subsequent writes read back correctly.
